// File: rtl/decode_queue.sv
`default_nettype none
// decode_queue: MIPS word decoder with a DEPTH-entry circular buffer between F/D and the D stage.
// Rev 1.0
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_cls,
  output logic [4:0]      out_wa,
  output logic            out_ri
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [3:0] CLS_NOP     = 4'd0;
  localparam logic [3:0] CLS_RALU    = 4'd1;
  localparam logic [3:0] CLS_IALU    = 4'd2;
  localparam logic [3:0] CLS_LOAD    = 4'd3;
  localparam logic [3:0] CLS_STORE   = 4'd4;
  localparam logic [3:0] CLS_BRANCH  = 4'd5;
  localparam logic [3:0] CLS_JAL     = 4'd6;
  localparam logic [3:0] CLS_JR      = 4'd7;
  localparam logic [3:0] CLS_MD      = 4'd8;
  localparam logic [3:0] CLS_MF      = 4'd9;
  localparam logic [3:0] CLS_MT      = 4'd10;
  localparam logic [3:0] CLS_MFC0    = 4'd11;
  localparam logic [3:0] CLS_MTC0    = 4'd12;
  localparam logic [3:0] CLS_ERET    = 4'd13;
  localparam logic [3:0] CLS_SYSCALL = 4'd14;
  localparam logic [3:0] CLS_RI      = 4'd15;

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [3:0]      cls_mem   [DEPTH];
  logic [4:0]      wa_mem    [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [3:0]    dec_cls;
  logic [4:0]    dec_wa;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign funct = in_instr[5:0];

  always_comb begin
    dec_cls = CLS_RI;
    case (op)
      6'b000000: begin
        case (funct)
          6'b000000: dec_cls = CLS_NOP;
          6'b100000, 6'b100010, 6'b100100,
          6'b100101, 6'b101010, 6'b101011: dec_cls = CLS_RALU;
          6'b001000: dec_cls = CLS_JR;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_cls = CLS_MD;
          6'b010000, 6'b010010: dec_cls = CLS_MF;
          6'b010001, 6'b010011: dec_cls = CLS_MT;
          6'b001100: dec_cls = CLS_SYSCALL;
          default:   dec_cls = CLS_RI;
        endcase
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001111: dec_cls = CLS_IALU;
      6'b100011, 6'b100001, 6'b100000:            dec_cls = CLS_LOAD;
      6'b101011, 6'b101001, 6'b101000:            dec_cls = CLS_STORE;
      6'b000100, 6'b000101:                       dec_cls = CLS_BRANCH;
      6'b000011:                                  dec_cls = CLS_JAL;
      6'b010000: begin
        if (rs == 5'b00000)
          dec_cls = CLS_MFC0;
        else if (rs == 5'b00100)
          dec_cls = CLS_MTC0;
        else if (rs == 5'b10000 && funct == 6'b011000)
          dec_cls = CLS_ERET;
        else
          dec_cls = CLS_RI;
      end
      default: dec_cls = CLS_RI;
    endcase
  end

  always_comb begin
    dec_wa = 5'd0;
    case (dec_cls)
      CLS_RALU, CLS_MF:            dec_wa = rd;
      CLS_IALU, CLS_LOAD, CLS_MFC0: dec_wa = rt;
      CLS_JAL:                     dec_wa = 5'd31;
      default:                     dec_wa = 5'd0;
    endcase
  end

  // in_ready depends only on registered count, so a pop cannot free a slot for the same-cycle push.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= in_instr;
      pc_mem[tail]    <= in_pc;
      cls_mem[tail]   <= dec_cls;
      wa_mem[tail]    <= dec_wa;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_instr = out_valid ? instr_mem[head] : 32'd0;
  assign out_pc    = out_valid ? pc_mem[head]    : '0;
  assign out_cls   = out_valid ? cls_mem[head]   : 4'd0;
  assign out_wa    = out_valid ? wa_mem[head]    : 5'd0;
  assign out_ri    = out_valid && (cls_mem[head] == CLS_RI);
endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// tb_decode_queue: scoreboard bench; expected decode results are queued at push and compared at the head.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic            in_ready, out_valid, out_ri;
  logic [31:0]     in_instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [3:0]      out_cls;
  logic [4:0]      out_wa;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  wa;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_cls(out_cls), .out_wa(out_wa), .out_ri(out_ri)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_instr", 64'(out_instr), 64'(sb[0].instr));
      check("out_pc", 64'(out_pc), 64'(sb[0].pc));
      check("out_cls", 64'(out_cls), 64'(sb[0].cls));
      check("out_wa", 64'(out_wa), 64'(sb[0].wa));
      check("out_ri", 64'(out_ri), 64'(sb[0].cls == 4'd15));
    end else begin
      check("idle_instr", 64'(out_instr), 64'd0);
      check("idle_pc", 64'(out_pc), 64'd0);
      check("idle_cls", 64'(out_cls), 64'd0);
      check("idle_wa", 64'(out_wa), 64'd0);
      check("idle_ri", 64'(out_ri), 64'd0);
    end
  endtask

  // One clock: check current outputs, drive inputs, advance, update the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [3:0] cls, input logic [4:0] wa,
                      input logic rdy, input logic fl);
    logic acc_push, acc_pop;
    exp_t e;
    check_outputs();
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    acc_push  = v && (sb.size() < DEPTH);
    acc_pop   = rdy && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (acc_pop) void'(sb.pop_front());
      if (acc_push) begin
        e.instr = ins; e.pc = pc; e.cls = cls; e.wa = wa;
        sb.push_back(e);
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, 4'd0, 5'd0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1'b0);
    idle(1'b0);

    // Single add into empty buffer, visible next cycle
    step(1'b1, 32'h00851020, 32'h3000, 4'd1, 5'd2, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill to DEPTH with out_ready low, then a fifth push alongside a pop
    step(1'b1, 32'h00021080, 32'h3100, 4'd0,  5'd0, 1'b0, 1'b0);
    step(1'b1, 32'h20030005, 32'h3104, 4'd2,  5'd3, 1'b0, 1'b0);
    step(1'b1, 32'hAC880004, 32'h3108, 4'd4,  5'd0, 1'b0, 1'b0);
    step(1'b1, 32'h10850003, 32'h310C, 4'd5,  5'd0, 1'b0, 1'b0);
    step(1'b1, 32'h03E00008, 32'h3110, 4'd7,  5'd0, 1'b1, 1'b0);
    check("count_after_refused", 64'(sb.size()), 64'd3);
    step(1'b1, 32'h00850018, 32'h3114, 4'd8,  5'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00003812, 32'h3118, 4'd9,  5'd7, 1'b1, 1'b0);
    step(1'b1, 32'h00800011, 32'h311C, 4'd10, 5'd0, 1'b1, 1'b0);
    step(1'b1, 32'h40856000, 32'h3120, 4'd12, 5'd0, 1'b1, 1'b0);
    step(1'b1, 32'h42000018, 32'h3124, 4'd13, 5'd0, 1'b1, 1'b0);
    step(1'b1, 32'h0000000C, 32'h3128, 4'd14, 5'd0, 1'b1, 1'b0);
    drain();

    // Destination-register resolution and reserved instruction
    step(1'b1, 32'h8C880004, 32'h3200, 4'd3,  5'd8,  1'b0, 1'b0);
    step(1'b1, 32'h0C000C00, 32'h3204, 4'd6,  5'd31, 1'b0, 1'b0);
    step(1'b1, 32'h40056000, 32'h3208, 4'd11, 5'd5,  1'b0, 1'b0);
    step(1'b1, 32'hFC000000, 32'h320C, 4'd15, 5'd0,  1'b0, 1'b0);
    drain();

    // Three held entries, then push together with flush
    step(1'b1, 32'h00851020, 32'h3300, 4'd1, 5'd2, 1'b0, 1'b0);
    step(1'b1, 32'h20030005, 32'h3304, 4'd2, 5'd3, 1'b0, 1'b0);
    step(1'b1, 32'h8C880004, 32'h3308, 4'd3, 5'd8, 1'b0, 1'b0);
    step(1'b1, 32'hFC000000, 32'h330C, 4'd15, 5'd0, 1'b1, 1'b0);
    step(1'b1, 32'h0C000C00, 32'h3310, 4'd6, 5'd31, 1'b1, 1'b1);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h00003812, 32'h3314, 4'd9, 5'd7, 1'b0, 1'b0);
    drain();

    // Continuous push/pop across pointer wrap
    step(1'b1, 32'h20000000, 32'h4000, 4'd2, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      step(1'b1, 32'h20000000 | (32'(i) << 16) | 32'(i), 32'h4000 + 32'(4 * i),
           4'd2, 5'(i), 1'b1, 1'b0);
      check("stream_count", 64'(sb.size()), 64'd1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
